muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/rv32i_types_pkg.sv | 16 +
 rtl/muldiv_sign_fix.sv | 44 ++++
 rtl/muldiv_unit.sv | 137 +++++++++++++
 tb/tb_muldiv_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I operation encodings for the execute-stage units.
package rv32i_types_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } ALU_op_enum;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } MD_op_enum;

  function automatic logic md_is_div(input MD_op_enum op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Sign handling around the unsigned iterative datapath: operand magnitudes on the
// request side, and two's-complement correction of the raw result on the way out.
module muldiv_sign_fix
  import rv32i_types_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  MD_op_enum               req_op,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [DATA_WIDTH-1:0]   mag_a,
  output logic [DATA_WIDTH-1:0]   mag_b,
  output logic                    res_neg,
  input  MD_op_enum               op,
  input  logic                    neg,
  input  logic [DATA_WIDTH-1:0]   raw_hi,
  input  logic [DATA_WIDTH-1:0]   raw_lo,
  output logic [DATA_WIDTH-1:0]   result
);

  logic sign_a, sign_b;

  always_comb begin
    sign_a  = (req_op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) && a[DATA_WIDTH-1];
    sign_b  = (req_op inside {MD_MULH, MD_DIV, MD_REM}) && b[DATA_WIDTH-1];
    mag_a   = sign_a ? (~a + 1'b1) : a;
    mag_b   = sign_b ? (~b + 1'b1) : b;
    // Remainder follows the dividend; everything else follows the sign product.
    res_neg = (req_op inside {MD_MULHSU, MD_REM}) ? sign_a : (sign_a ^ sign_b);
  end

  always_comb begin
    result = raw_lo;
    unique case (op)
      MD_MUL, MD_DIV, MD_DIVU: result = neg ? (~raw_lo + 1'b1) : raw_lo;
      // High half of a negated 2W product: carry into it only when the low half is zero.
      MD_MULH, MD_MULHSU, MD_MULHU:
        result = neg ? (~raw_hi + {{(DATA_WIDTH-1){1'b0}}, (raw_lo == '0)}) : raw_hi;
      MD_REM, MD_REMU: result = neg ? (~raw_hi + 1'b1) : raw_hi;
      default: result = raw_lo;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit with valid/ready handshakes and
// single-cycle fast paths for divide-by-zero and signed overflow.
module muldiv_unit
  import rv32i_types_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  MD_op_enum             MD_op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MostNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                state_q, state_d;
  MD_op_enum             op_q;
  logic                  neg_q;
  logic [CntW-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0] acc_hi_q, acc_lo_q, acc_b_q;
  logic [DATA_WIDTH-1:0] acc_hi_d, acc_lo_d;

  logic                  accept, div_zero, div_ovf, fast;
  logic [DATA_WIDTH-1:0] fast_result, mag_a, mag_b, fixed_result;
  logic                  res_neg;
  logic [DATA_WIDTH:0]   mul_sum, div_shift;
  logic [DATA_WIDTH-1:0] div_diff;
  logic                  div_ge;

  muldiv_sign_fix #(.DATA_WIDTH(DATA_WIDTH)) u_sign_fix (
    .req_op  (MD_op),
    .a       (A),
    .b       (B),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .res_neg (res_neg),
    .op      (op_q),
    .neg     (neg_q),
    .raw_hi  (acc_hi_d),
    .raw_lo  (acc_lo_d),
    .result  (fixed_result)
  );

  always_comb begin
    accept      = in_valid && in_ready && !flush;
    div_zero    = md_is_div(MD_op) && (B == '0);
    div_ovf     = (MD_op inside {MD_DIV, MD_REM}) && (A == MostNeg) && (B == '1);
    fast        = div_zero || div_ovf;
    fast_result = '0;
    if (div_zero) begin
      fast_result = (MD_op inside {MD_DIV, MD_DIVU}) ? '1 : A;
    end else if (div_ovf) begin
      fast_result = (MD_op == MD_DIV) ? A : '0;
    end
  end

  // One iteration: shift-add multiply (product in {hi,lo}) or restoring divide
  // (partial remainder in hi, dividend shifting out / quotient shifting into lo).
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, acc_b_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[DATA_WIDTH-1]};
    div_ge    = div_shift >= {1'b0, acc_b_q};
    div_diff  = div_shift[DATA_WIDTH-1:0] - acc_b_q;
    if (md_is_div(op_q)) begin
      acc_hi_d = div_ge ? div_diff : div_shift[DATA_WIDTH-1:0];
      acc_lo_d = {acc_lo_q[DATA_WIDTH-2:0], div_ge};
    end else begin
      acc_hi_d = mul_sum[DATA_WIDTH:1];
      acc_lo_d = {mul_sum[0], acc_lo_q[DATA_WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    case (state_q)
      IDLE:    if (accept) state_d = fast ? DONE : BUSY;
      BUSY:    if (cnt_q == LastIter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= MD_MUL;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      acc_b_q  <= '0;
      result   <= '0;
      out_tag  <= '0;
    end else if (!flush) begin
      if (accept) begin
        op_q     <= MD_op;
        neg_q    <= res_neg;
        cnt_q    <= '0;
        acc_hi_q <= '0;
        acc_lo_q <= mag_a;
        acc_b_q  <= mag_b;
        out_tag  <= in_tag;
        if (fast) result <= fast_result;
      end else if (state_q == BUSY) begin
        acc_hi_q <= acc_hi_d;
        acc_lo_q <= acc_lo_d;
        cnt_q    <= cnt_q + CntW'(1);
        if (cnt_q == LastIter) result <= fixed_result;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at DATA_WIDTH=32.
module tb_muldiv_unit;
  import rv32i_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  MD_op_enum   md_op = MD_MUL;
  logic [31:0] a_in = '0, b_in = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  out_tag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .MD_op     (md_op),
    .A         (a_in),
    .B         (b_in),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    a_in   = $urandom;
    b_in   = $urandom;
    in_tag = 5'($urandom);
    md_op  = MD_op_enum'($urandom_range(0, 7));
  endtask

  // Issue one request, measure edges to out_valid, check result/tag, optionally stall.
  task automatic run_op(input MD_op_enum op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input int exp_lat,
                        input int stall);
    int edges;
    @(negedge clk);
    md_op = op; a_in = a; b_in = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    check_eq("in_ready_after_accept", 32'(in_ready), 32'd0);
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    check_eq("latency", edges, exp_lat);
    check_eq("result", result, exp);
    check_eq("out_tag", 32'(out_tag), 32'(tag));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      scramble();
      in_valid = 1'b1;
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      check_eq("stall_result", result, exp);
      check_eq("stall_tag", 32'(out_tag), 32'(tag));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq("handshake_out_valid", 32'(out_valid), 32'd0);
    check_eq("handshake_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    #2;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_out_tag", 32'(out_tag), 32'd0);
    #10 rst_n = 1'b1;

    run_op(MD_MUL,    32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 32, 0);
    run_op(MD_MULH,   32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 32, 0);
    run_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 32, 0);
    run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, 32, 0);
    run_op(MD_DIV,    32'hFFFF_FFF9, 32'd2,        5'd7,  32'hFFFF_FFFD, 32, 0);
    run_op(MD_REM,    32'hFFFF_FFF9, 32'd2,        5'd8,  32'hFFFF_FFFF, 32, 0);
    run_op(MD_DIVU,   32'd100,      32'd7,         5'd9,  32'd14,        32, 10);
    run_op(MD_REMU,   32'd100,      32'd7,         5'd10, 32'd2,         32, 0);
    run_op(MD_DIV,    32'd5,        32'd0,         5'd11, 32'hFFFF_FFFF, 0,  0);
    run_op(MD_REMU,   32'd5,        32'd0,         5'd12, 32'd5,         0,  0);
    run_op(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 0, 0);
    run_op(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,        0,  0);

    // Flush on the 16th iteration edge while a new request is offered.
    @(negedge clk);
    md_op = MD_MUL; a_in = 32'd3; b_in = 32'd5; in_tag = 5'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; md_op = MD_DIVU; a_in = 32'd9; b_in = 32'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_in_ready", 32'(in_ready), 32'd1);
    check_eq("flush_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) seen = 1;
    end
    check_eq("flush_stays_idle", seen, 0);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    md_op = MD_DIVU; a_in = 32'd1000; b_in = 32'd3; in_tag = 5'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midreset_out_valid", 32'(out_valid), 32'd0);
    check_eq("midreset_in_ready", 32'(in_ready), 32'd1);
    check_eq("midreset_out_tag", 32'(out_tag), 32'd0);
    check_eq("midreset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(MD_DIVU, 32'd1000, 32'd3, 5'd21, 32'd333, 32, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
